sd_cmd_phy: RTL
===============

// Module: sd_cmd_phy
// PURPOSE
//  Command-line PHY under the SD command layer. Serialises a 40-bit command with
//  CRC7 and end bit onto the SD CMD line, waits for the response start bit with
//  timeout, shifts in a 48- or 136-bit response, checks its CRC7 and reports
//  done/CRC/timeout. All line activity advances on a bit strobe from the SD clock divider.
// PARAMETERS
//  NCC_BITS  8  idle bit-strobes (CMD line released, high) after each transaction before IDLE
//  NCR_MIN   2  bit-strobes after the command end bit before a start bit is accepted
// PORTS
//  clk                 in   1    system clock
//  rst                 in   1    asynchronous, active-high reset
//  i_stb               in   1    one-cycle bit strobe; line sampled/driven only when high
//  i_cmd_en            in   1    level request from cmd layer; drop = abort
//  i_cmd               in   40   {start,dir,index[5:0],arg[31:0]}, MSB first
//  i_cmd_len           in   8    command payload bits to send (1..40, from i_cmd[39] down)
//  i_rsp_len           in   8    0 = no response, 40 = short (R1/R3/R6/R7), 136 = long (R2)
//  i_timeout           in   16   max strobes waiting for start bit (0 => 65536)
//  o_rsp_finished_en   out  1    level: transaction complete, held until i_cmd_en low
//  o_rsp               out  136  received frame, right-aligned (last bit received in [0])
//  o_crc_bad           out  1    CRC7 mismatch, valid with o_rsp_finished_en
//  o_timeout           out  1    no start bit seen, valid with o_rsp_finished_en
//  o_busy              out  1    state != IDLE
//  o_sd_cmd_dir        out  1    1 = drive CMD pad, 0 = release (pull-up)
//  o_sd_cmd            out  1    CMD pad output value
//  i_sd_cmd            in   1    CMD pad input (already synchronised)
// BEHAVIOUR
//  Reset: state IDLE; o_sd_cmd=1, o_sd_cmd_dir=0, o_rsp=0, all flags/o_busy 0.
//  States: IDLE -> TX -> TURN -> WAIT_START -> RX -> CHECK -> DONE -> GAP -> IDLE.
//  IDLE: i_cmd_en high => latch i_cmd/lens/timeout, clear o_rsp, crc7=0, flags 0, -> TX.
//  TX: on each i_stb drive next bit, dir=1: i_cmd_len payload bits, crc7[6:0], end bit 1.
//   CRC7 poly x^7+x^3+1, bit-serial over payload bits only. After end bit, -> TURN.
//  TURN: release (dir=0, o_sd_cmd=1). i_rsp_len==0 -> DONE directly; else wait NCR_MIN
//   strobes, -> WAIT_START with timeout count 0.
//  WAIT_START: per strobe, i_sd_cmd==0 => store as frame bit 1, -> RX; else count+1;
//   count==i_timeout (0 => 65536) => o_timeout=1, -> DONE.
//  RX: shift i_sd_cmd into o_rsp[0] per strobe (o_rsp <= {o_rsp[134:0],bit}) until
//   F bits total: F=48 if i_rsp_len==40, F=136 if i_rsp_len==136; other nonzero: F=i_rsp_len+8.
//  CHECK (one clk, no strobe needed): short: CRC7 over frame bits 47:8 vs o_rsp[7:1];
//   long: CRC7 over bits 127:8 vs o_rsp[7:1] (start/tx/reserved excluded). Mismatch
//   or o_rsp[0]==0 (bad end bit) => o_crc_bad=1. CRC may be accumulated during RX.
//  DONE: o_rsp_finished_en=1, o_rsp/flags frozen; stays until i_cmd_en low -> GAP.
//  GAP: line released, NCC_BITS strobes, then IDLE; i_cmd_en ignored until IDLE.
//  Abort: i_cmd_en low in any state before DONE => release line next clk, flags 0,
//   o_rsp_finished_en 0, -> GAP. rst at any time => reset values immediately.
//  No strobe: state/bit counters hold; CHECK/DONE/abort transitions need no strobe.
//  Counters: bit counter 8-bit, timeout counter 17-bit; no wrap in valid use.
//  o_rsp_finished_en asserts at least one clk after o_crc_bad/o_timeout final.
// TESTING
//  CMD0 arg 0 (i_cmd=0x40_00000000, len 40, rsp 0) -> CMD bits 0x400000000095, then
//   released; finished, crc_bad 0, timeout 0.
//  CMD8 arg 0x1AA, rsp 40, card returns 0x08000001AA13 after 5 strobes -> o_rsp[47:0]
//   =0x08000001AA13, crc_bad 0.
//  Same as above with response CRC byte 0x15 -> o_crc_bad=1, finished asserted.
//  i_timeout=16, CMD line held high -> o_timeout=1 after exactly 16 WAIT_START
//   strobes, o_rsp=0.
//  R2 with 136-bit frame carrying valid CRC -> o_rsp[135:0] equals frame, crc_bad 0.
//  Drop i_cmd_en mid-TX (bit 20) -> dir=0 next clk, no finished, new request
//   accepted only after NCC_BITS strobes.

Source files
------------

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: sends a command frame with CRC7 and waits for the response start bit.
// It then captures a 48- or 136-bit response and reports completion, CRC status and timeout.
module sd_cmd_phy #(
    parameter int NCC_BITS = 8,
    parameter int NCR_MIN  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_stb,
    input  logic         i_cmd_en,
    input  logic [39:0]  i_cmd,
    input  logic [7:0]   i_cmd_len,
    input  logic [7:0]   i_rsp_len,
    input  logic [15:0]  i_timeout,
    output logic         o_rsp_finished_en,
    output logic [135:0] o_rsp,
    output logic         o_crc_bad,
    output logic         o_timeout,
    output logic         o_busy,
    output logic         o_sd_cmd_dir,
    output logic         o_sd_cmd,
    input  logic         i_sd_cmd
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TX         = 3'd1,
        ST_TURN       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_RX         = 3'd4,
        ST_CHECK      = 3'd5,
        ST_DONE       = 3'd6,
        ST_GAP        = 3'd7
    } state_t;

    localparam logic [7:0] NCC_LAST = 8'(NCC_BITS - 1);
    localparam logic [7:0] NCR_LAST = 8'(NCR_MIN - 1);

    // Bit-serial CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t      state_r;
    logic [39:0] cmd_r;
    logic [7:0]  cmd_len_r;
    logic [7:0]  rsp_len_r;
    logic [7:0]  frame_len_r;
    logic        long_r;
    logic [15:0] timeout_r;
    logic [7:0]  bit_cnt_r;
    logic [16:0] tmo_cnt_r;
    logic [6:0]  crc_r;

    logic [8:0]  tx_idx_s;
    logic        tx_payload_s;
    logic        tx_last_s;
    logic        tx_bit_s;
    logic [7:0]  rx_n_s;
    logic        rx_in_crc_s;
    logic [16:0] tmo_next_s;
    logic [16:0] tmo_limit_s;
    logic [7:0]  frame_len_s;
    logic        abort_s;

    // Next-bit selection for the command frame: payload, then CRC7, then end bit
    always_comb begin
        tx_idx_s     = {1'b0, bit_cnt_r};
        tx_payload_s = (tx_idx_s < {1'b0, cmd_len_r});
        tx_last_s    = (tx_idx_s == ({1'b0, cmd_len_r} + 9'd7));
        if (tx_payload_s) begin
            tx_bit_s = cmd_r[39];
        end else if (!tx_last_s) begin
            tx_bit_s = crc_r[6];
        end else begin
            tx_bit_s = 1'b1;
        end
    end

    // Response bookkeeping: frame position, CRC coverage window and timeout limit
    always_comb begin
        rx_n_s      = bit_cnt_r + 8'd1;
        rx_in_crc_s = (rx_n_s >= (long_r ? 8'd9 : 8'd1)) && (rx_n_s <= (frame_len_r - 8'd8));
        tmo_next_s  = tmo_cnt_r + 17'd1;
        if (timeout_r == 16'd0) begin
            tmo_limit_s = 17'h10000;
        end else begin
            tmo_limit_s = {1'b0, timeout_r};
        end
        if (i_rsp_len == 8'd40) begin
            frame_len_s = 8'd48;
        end else if (i_rsp_len == 8'd136) begin
            frame_len_s = 8'd136;
        end else begin
            frame_len_s = i_rsp_len + 8'd8;
        end
    end

    // Abort applies only before the result is published
    always_comb begin
        case (state_r)
            ST_TX, ST_TURN, ST_WAIT_START, ST_RX, ST_CHECK: abort_s = !i_cmd_en;
            default:                                        abort_s = 1'b0;
        endcase
    end

    // Transaction FSM with registered line and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            cmd_r             <= 40'd0;
            cmd_len_r         <= 8'd0;
            rsp_len_r         <= 8'd0;
            frame_len_r       <= 8'd0;
            long_r            <= 1'b0;
            timeout_r         <= 16'd0;
            bit_cnt_r         <= 8'd0;
            tmo_cnt_r         <= 17'd0;
            crc_r             <= 7'd0;
            o_rsp_finished_en <= 1'b0;
            o_rsp             <= 136'd0;
            o_crc_bad         <= 1'b0;
            o_timeout         <= 1'b0;
            o_busy            <= 1'b0;
            o_sd_cmd_dir      <= 1'b0;
            o_sd_cmd          <= 1'b1;
        end else if (abort_s) begin
            state_r           <= ST_GAP;
            bit_cnt_r         <= 8'd0;
            o_sd_cmd_dir      <= 1'b0;
            o_sd_cmd          <= 1'b1;
            o_crc_bad         <= 1'b0;
            o_timeout         <= 1'b0;
            o_rsp_finished_en <= 1'b0;
            o_busy            <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_cmd_en) begin
                        state_r           <= ST_TX;
                        cmd_r             <= i_cmd;
                        cmd_len_r         <= i_cmd_len;
                        rsp_len_r         <= i_rsp_len;
                        frame_len_r       <= frame_len_s;
                        long_r            <= (i_rsp_len == 8'd136);
                        timeout_r         <= i_timeout;
                        bit_cnt_r         <= 8'd0;
                        tmo_cnt_r         <= 17'd0;
                        crc_r             <= 7'd0;
                        o_rsp             <= 136'd0;
                        o_crc_bad         <= 1'b0;
                        o_timeout         <= 1'b0;
                        o_rsp_finished_en <= 1'b0;
                        o_busy            <= 1'b1;
                    end
                end
                ST_TX: begin
                    if (i_stb) begin
                        o_sd_cmd_dir <= 1'b1;
                        o_sd_cmd     <= tx_bit_s;
                        if (tx_payload_s) begin
                            cmd_r     <= {cmd_r[38:0], 1'b0};
                            crc_r     <= crc7_step(crc_r, cmd_r[39]);
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end else if (!tx_last_s) begin
                            crc_r     <= {crc_r[5:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end else begin
                            // CRC register is reused to accumulate the response CRC
                            crc_r     <= 7'd0;
                            bit_cnt_r <= 8'd0;
                            state_r   <= ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    if (i_stb) begin
                        o_sd_cmd_dir <= 1'b0;
                        o_sd_cmd     <= 1'b1;
                        if (rsp_len_r == 8'd0) begin
                            state_r <= ST_DONE;
                        end else if (bit_cnt_r >= NCR_LAST) begin
                            state_r   <= ST_WAIT_START;
                            tmo_cnt_r <= 17'd0;
                            bit_cnt_r <= 8'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (i_stb) begin
                        if (!i_sd_cmd) begin
                            // Start bit is a zero; CRC of a leading zero from zero is zero
                            o_rsp     <= {o_rsp[134:0], 1'b0};
                            bit_cnt_r <= 8'd1;
                            state_r   <= ST_RX;
                        end else if (tmo_next_s == tmo_limit_s) begin
                            o_timeout <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            tmo_cnt_r <= tmo_next_s;
                        end
                    end
                end
                ST_RX: begin
                    if (i_stb) begin
                        o_rsp     <= {o_rsp[134:0], i_sd_cmd};
                        bit_cnt_r <= rx_n_s;
                        if (rx_in_crc_s) begin
                            crc_r <= crc7_step(crc_r, i_sd_cmd);
                        end
                        if (rx_n_s == frame_len_r) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    o_crc_bad <= (crc_r != o_rsp[7:1]) || !o_rsp[0];
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (!i_cmd_en) begin
                        o_rsp_finished_en <= 1'b0;
                        bit_cnt_r         <= 8'd0;
                        state_r           <= ST_GAP;
                    end else begin
                        o_rsp_finished_en <= 1'b1;
                    end
                end
                ST_GAP: begin
                    o_sd_cmd_dir <= 1'b0;
                    o_sd_cmd     <= 1'b1;
                    if (i_stb) begin
                        if (bit_cnt_r >= NCC_LAST) begin
                            bit_cnt_r <= 8'd0;
                            o_busy    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    o_busy       <= 1'b0;
                    o_sd_cmd_dir <= 1'b0;
                    o_sd_cmd     <= 1'b1;
                end
            endcase
        end
    end

endmodule
